elevator_controller: RTL and testbench
======================================

// Module: elevator_controller
// PURPOSE
//  Car controller for the 3-floor elevator. It consumes the active-low floor buttons and the slow
//  timing clock from the frequency divider, and produces the `moving` status that the divider reads
//  back. It latches requests, chooses a direction, steps the car one floor per travel period and
//  holds the door open at served floors. The fast board clock (clk_50) drives every flop.
// PARAMETERS
//  TRAVEL_TICKS  4   tick rising edges needed to move one floor (>=1)
//  DOOR_TICKS    3   tick rising edges the door stays open (>=1)
//  SYNC_STAGES   2   synchronizer depth on buttons and tick (>=2)
// PORTS
//  clk_50     in   1  system clock; all logic on its rising edge
//  reset      in   1  synchronous, active-high reset
//  button1    in   1  floor-1 call, active-low; each press is held low for >=1 clk_50 period
//  button2    in   1  floor-2 call, active-low
//  button3    in   1  floor-3 call, active-low
//  tick       in   1  slow clock from the frequency block; only its rising edges are used
//  moving     out  1  car travelling between floors; fed back to the frequency block
//  floor      out  2  current floor, 1..3 (never 0)
//  direction  out  1  1 = up, 0 = down
//  door_open  out  1  door open at the current floor
//  requests   out  3  pending calls; bit k-1 is floor k
// BEHAVIOUR
//  - Reset: floor=1, direction=1, moving=0, door_open=0, requests=000, state IDLE, counters=0.
//    Reset during motion or with the door open takes effect on the next edge; no state is kept.
//  - All outputs are registered.
//  - Buttons pass through a SYNC_STAGES synchronizer. A press is a synchronized 1->0 transition.
//    With the default depth, the press is reflected in requests on the 3rd clk_50 edge after the
//    low level is first sampled. A level held low produces exactly one press.
//  - tick passes through the same synchronizer. tick_rise is a one-cycle pulse on each 0->1 edge.
//  - States and transitions:
//    - IDLE:
//      - If the request for the current floor is set, clear it and go to DOOR.
//      - Otherwise, if a request exists in the current direction, go MOVE with that direction.
//      - Otherwise, if a request exists in the opposite direction, flip direction and go MOVE.
//      - Otherwise stay in IDLE.
//      - moving=1 from the same edge that enters MOVE.
//    - MOVE:
//      - travel_cnt advances on each tick_rise.
//      - On the tick_rise where travel_cnt==TRAVEL_TICKS-1: floor moves by +/-1 and travel_cnt
//        clears.
//      - If the new floor is requested: clear that bit, set moving=0, door_open=1, go to DOOR.
//      - Otherwise stay in MOVE.
//    - DOOR:
//      - door_cnt advances on each tick_rise.
//      - On the tick_rise where door_cnt==DOOR_TICKS-1: door_open=0, go to IDLE.
//  - Presses and requests:
//    - A press for the current floor while in DOOR restarts door_cnt and does not latch.
//    - A press for the current floor while in IDLE opens the door and does not latch.
//    - Any other press sets its bit.
//    - If a set and a clear of the same bit coincide, the clear wins (the call is being served).
//  - floor is clamped to 1..3. MOVE only starts toward a pending request, so the car never runs
//    past floor 1 or floor 3.
//  - A tick_rise and a press in the same cycle are both processed.
//  - Without tick_rise, MOVE and DOOR hold every output.
// STRUCTURE
//  - elevator_pkg holds:
//    - state localparams: IDLE=2'd0, MOVE=2'd1, DOOR=2'd2
//    - NUM_FLOORS=3, FLOOR_W=2, DIR_UP=1'b1, DIR_DOWN=1'b0
//  - One sub-module, edge_sync: SYNC_STAGES flop chain plus edge detector, with a parameter that
//    selects rising or falling edge.
//    - Three instances for the buttons (falling edge).
//    - One instance for tick (rising edge).
//  - Everything else is the FSM, the two counters and the request register in this module.
// TESTING (defaults; tick period = 8 clk_50 cycles)
//  1. Reset held for 2 cycles -> floor=1, direction=1, moving=0, door_open=0, requests=000.
//  2. From idle at floor 1, button3 low for 1 cycle:
//     -> requests=100 on the 3rd edge, then moving=1.
//     -> floor=2 after 4 tick rises; floor=3 after 8 tick rises, with moving=0, door_open=1,
//        requests=000.
//     -> door_open=0 after 3 more tick rises.
//  3. Idle at floor 1, press button1 -> door_open=1, moving stays 0, requests stays 000.
//  4. Car moving 1->3, press button2 before the 4th tick rise:
//     -> stops at floor=2 with door_open=1 and requests=100.
//     -> then resumes up and reaches floor=3.
//  5. Reset asserted mid-move at floor=2 with moving=1 -> next edge floor=1, moving=0,
//     requests=000.
//  6. At floor 3 with the door open, press button1:
//     -> after the door closes, direction=0 and moving=1.
//     -> floor=1 after 8 tick rises, then door_open=1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the 3-floor elevator car controller.
// Floors are numbered 1..NUM_FLOORS; request bit k-1 belongs to floor k.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam int NUM_FLOORS = 3;
    localparam int FLOOR_W    = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [FLOOR_W-1:0] BOT_FLOOR = 2'd1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = 2'd3;

    // One-hot request mask for a floor number
    function automatic logic [NUM_FLOORS-1:0] floor_bit(
        input logic [FLOOR_W-1:0] f
    );
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        unique case (f)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchronizer followed by a single-cycle edge detector.
// RISING selects 0->1 detection; otherwise 1->0 is detected.
module edge_sync #(
    parameter int STAGES = 2,
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    // Resting level before the edge of interest, so reset never fakes an edge
    localparam logic REST = !RISING;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              last_q;
    logic              last_d;

    // Shift the raw input through the chain and remember the last settled value
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        last_d = sync_q[STAGES-1];
    end

    // Synchronizer and history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{REST}};
            last_q <= REST;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign pulse = RISING ? (sync_q[STAGES-1] & ~last_q)
                          : (~sync_q[STAGES-1] & last_q);

endmodule

// File: rtl/elevator_controller.sv
// Car controller: latches floor calls, picks a direction, steps one floor
// per travel period and holds the door open at served floors.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic               button1,
    input  logic               button2,
    input  logic               button3,
    input  logic               tick,
    output logic               moving,
    output logic [FLOOR_W-1:0] floor,
    output logic               direction,
    output logic               door_open,
    output logic [NUM_FLOORS-1:0] requests
);

    localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DOOR_TICKS - 1);

    logic [NUM_FLOORS-1:0] press;
    logic                  tick_rise;

    edge_sync #(.STAGES(SYNC_STAGES), .RISING(1'b0)) u_b1 (
        .clk(clk_50), .reset(reset), .din(button1), .pulse(press[0])
    );
    edge_sync #(.STAGES(SYNC_STAGES), .RISING(1'b0)) u_b2 (
        .clk(clk_50), .reset(reset), .din(button2), .pulse(press[1])
    );
    edge_sync #(.STAGES(SYNC_STAGES), .RISING(1'b0)) u_b3 (
        .clk(clk_50), .reset(reset), .din(button3), .pulse(press[2])
    );
    edge_sync #(.STAGES(SYNC_STAGES), .RISING(1'b1)) u_tick (
        .clk(clk_50), .reset(reset), .din(tick), .pulse(tick_rise)
    );

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic                  moving_q, moving_d;
    logic                  door_q, door_d;
    logic [NUM_FLOORS-1:0] req_q, req_d;
    logic [TW-1:0]         travel_q, travel_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;

    logic [NUM_FLOORS-1:0] cur, nbit, above, below, set_v, clr_v;
    logic [FLOOR_W-1:0]    nf;

    // Neighbour floor in the travel direction and request masks around the car
    always_comb begin
        above = '0;
        below = '0;
        unique case (floor_q)
            2'd1:    above = 3'b110;
            2'd2:    begin above = 3'b100; below = 3'b001; end
            2'd3:    below = 3'b011;
            default: begin above = '0; below = '0; end
        endcase
        if (dir_q == DIR_UP && floor_q != TOP_FLOOR) begin
            nf = floor_q + 1'b1;
        end else if (dir_q == DIR_DOWN && floor_q != BOT_FLOOR) begin
            nf = floor_q - 1'b1;
        end else begin
            nf = floor_q;
        end
        cur  = floor_bit(floor_q);
        nbit = floor_bit(nf);
    end

    // Next-state, counters and request bookkeeping
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        door_d   = door_q;
        travel_d = travel_q;
        dcnt_d   = dcnt_q;
        set_v    = press;
        clr_v    = '0;
        unique case (state_q)
            IDLE: begin
                if (((req_q | press) & cur) != '0) begin
                    clr_v   = cur;
                    door_d  = 1'b1;
                    dcnt_d  = '0;
                    state_d = DOOR;
                end else if ((req_q & (dir_q ? above : below)) != '0) begin
                    moving_d = 1'b1;
                    travel_d = '0;
                    state_d  = MOVE;
                end else if ((req_q & (dir_q ? below : above)) != '0) begin
                    dir_d    = ~dir_q;
                    moving_d = 1'b1;
                    travel_d = '0;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
                if (tick_rise) begin
                    if (travel_q == T_LAST) begin
                        floor_d  = nf;
                        travel_d = '0;
                        if (((req_q | press) & nbit) != '0) begin
                            clr_v    = nbit;
                            moving_d = 1'b0;
                            door_d   = 1'b1;
                            dcnt_d   = '0;
                            state_d  = DOOR;
                        end
                    end else begin
                        travel_d = travel_q + 1'b1;
                    end
                end
            end
            DOOR: begin
                if ((press & cur) != '0) begin
                    set_v  = press & ~cur;
                    dcnt_d = '0;
                end else if (tick_rise) begin
                    if (dcnt_q == D_LAST) begin
                        door_d  = 1'b0;
                        dcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (req_q | set_v) & ~clr_v;
    end

    // Controller state registers
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q  <= IDLE;
            floor_q  <= BOT_FLOOR;
            dir_q    <= DIR_UP;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            req_q    <= '0;
            travel_q <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            door_q   <= door_d;
            req_q    <= req_d;
            travel_q <= travel_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign moving    = moving_q;
    assign floor     = floor_q;
    assign direction = dir_q;
    assign door_open = door_q;
    assign requests  = req_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: directed scenarios then random calls,
// all compared each cycle against a behavioural car model.
module tb_elevator_controller;

    localparam int TRAVEL = 4;
    localparam int DOORT  = 3;
    localparam int TPER   = 8;

    logic       clk_50 = 1'b0;
    logic       reset, button1, button2, button3, tick;
    logic       moving, direction, door_open;
    logic [1:0] floor;
    logic [2:0] requests;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int       m_floor, m_dir, m_mode, m_tc, m_dc;
    bit [3:1] m_req;
    bit       hist [4][4];

    elevator_controller #(
        .TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOORT), .SYNC_STAGES(2)
    ) dut (
        .clk_50(clk_50), .reset(reset),
        .button1(button1), .button2(button2), .button3(button3),
        .tick(tick), .moving(moving), .floor(floor),
        .direction(direction), .door_open(door_open),
        .requests(requests)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: a call is seen two edges after its first low
    // sample; the car visits requested floors and counts tick rises.
    task automatic model_edge(input bit rst, input bit [3:0] raw);
        bit [3:1] p, setv, clrv;
        bit       tr, up_any, dn_any;
        int       f;
        if (rst) begin
            m_floor = 1; m_dir = 1; m_mode = 0;
            m_tc = 0; m_dc = 0; m_req = '0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    hist[i][j] = (i < 3);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            hist[i][3] = hist[i][2];
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = raw[i];
        end
        for (int k = 1; k <= 3; k++)
            p[k] = hist[k-1][3] && !hist[k-1][2];
        tr = !hist[3][3] && hist[3][2];
        setv = p;
        clrv = '0;
        f = m_floor;
        up_any = 0;
        dn_any = 0;
        for (int k = 1; k <= 3; k++) begin
            if (m_req[k] && k > f) up_any = 1;
            if (m_req[k] && k < f) dn_any = 1;
        end
        case (m_mode)
            0: begin
                if (p[f] || m_req[f]) begin
                    clrv[f] = 1; m_mode = 2; m_dc = 0;
                end else if (m_dir ? up_any : dn_any) begin
                    m_mode = 1; m_tc = 0;
                end else if (m_dir ? dn_any : up_any) begin
                    m_dir = 1 - m_dir; m_mode = 1; m_tc = 0;
                end
            end
            1: begin
                if (tr) begin
                    m_tc++;
                    if (m_tc == TRAVEL) begin
                        m_tc = 0;
                        m_floor += m_dir ? 1 : -1;
                        if (m_floor > 3) m_floor = 3;
                        if (m_floor < 1) m_floor = 1;
                        if (m_req[m_floor] || p[m_floor]) begin
                            clrv[m_floor] = 1; m_mode = 2; m_dc = 0;
                        end
                    end
                end
            end
            default: begin
                if (p[f]) begin
                    setv[f] = 0; m_dc = 0;
                end else if (tr) begin
                    m_dc++;
                    if (m_dc == DOORT) begin
                        m_dc = 0; m_mode = 0;
                    end
                end
            end
        endcase
        m_req = (m_req | setv) & ~clrv;
    endtask

    task automatic step();
        @(posedge clk_50);
        model_edge(reset, {tick, button3, button2, button1});
        @(negedge clk_50);
        chk("floor", 32'(floor), 32'(m_floor));
        chk("direction", 32'(direction), 32'(m_dir));
        chk("moving", 32'(moving), 32'(m_mode == 1));
        chk("door_open", 32'(door_open), 32'(m_mode == 2));
        chk("requests", 32'(requests), 32'(m_req));
        cyc++;
        tick = (cyc % TPER) >= (TPER / 2);
    endtask

    function automatic logic [31:0] get(int sel);
        case (sel)
            0: return 32'(floor);
            1: return 32'(direction);
            2: return 32'(moving);
            3: return 32'(door_open);
            default: return 32'(requests);
        endcase
    endfunction

    task automatic wait_until(int sel, int val, int max, string tag);
        int n = 0;
        while (get(sel) !== 32'(val) && n < max) begin
            step();
            n++;
        end
        chk(tag, get(sel), 32'(val));
    endtask

    task automatic push(int k);
        if (k == 1) button1 = 1'b0;
        if (k == 2) button2 = 1'b0;
        if (k == 3) button3 = 1'b0;
        step();
        button1 = 1'b1; button2 = 1'b1; button3 = 1'b1;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0;
        button1 = 1'b1; button2 = 1'b1; button3 = 1'b1;
        step(); step();
        chk("rst_floor", 32'(floor), 1);
        chk("rst_dir", 32'(direction), 1);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_door", 32'(door_open), 0);
        chk("rst_req", 32'(requests), 0);
        reset = 1'b0;
        repeat (4) step();

        push(1); step(); step();
        chk("own_floor_door", 32'(door_open), 1);
        chk("own_floor_moving", 32'(moving), 0);
        chk("own_floor_req", 32'(requests), 0);
        wait_until(3, 0, 100, "own_floor_close");

        push(3); step(); step();
        chk("call3_req", 32'(requests), 3'b100);
        step();
        chk("call3_moving", 32'(moving), 1);
        wait_until(0, 2, 200, "call3_floor2");
        chk("call3_mid_moving", 32'(moving), 1);
        wait_until(3, 1, 200, "call3_door");
        chk("call3_floor3", 32'(floor), 3);
        chk("call3_stop", 32'(moving), 0);
        chk("call3_req_clr", 32'(requests), 0);

        push(1);
        wait_until(3, 0, 200, "down_close");
        wait_until(2, 1, 10, "down_moving");
        chk("down_dir", 32'(direction), 0);
        wait_until(3, 1, 400, "down_door");
        chk("down_floor1", 32'(floor), 1);
        wait_until(3, 0, 200, "down_close2");

        push(3);
        wait_until(2, 1, 20, "mid_moving");
        repeat (16) step();
        push(2);
        wait_until(3, 1, 200, "mid_door");
        chk("mid_floor2", 32'(floor), 2);
        chk("mid_req", 32'(requests), 3'b100);
        wait_until(3, 0, 200, "mid_close");
        wait_until(3, 1, 200, "mid_door3");
        chk("mid_floor3", 32'(floor), 3);
        wait_until(3, 0, 200, "mid_close3");

        push(1);
        wait_until(2, 1, 20, "rst_mv_moving");
        wait_until(0, 2, 200, "rst_mv_floor2");
        chk("rst_mv_pre", 32'(moving), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mv_floor", 32'(floor), 1);
        chk("rst_mv_moving0", 32'(moving), 0);
        chk("rst_mv_req", 32'(requests), 0);

        repeat (3000) begin
            if (button1) button1 = ($urandom_range(0, 29) != 0);
            else         button1 = ($urandom_range(0, 1) == 0);
            if (button2) button2 = ($urandom_range(0, 29) != 0);
            else         button2 = ($urandom_range(0, 1) == 0);
            if (button3) button3 = ($urandom_range(0, 29) != 0);
            else         button3 = ($urandom_range(0, 1) == 0);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
